// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment bus monitor: segment patterns (active low,
// bits g..a), scan FSM states and the per-digit value width.
package seg_pkg;

  localparam int DIG_W = 4;

  localparam logic [6:0] PAT_0     = 7'h40;
  localparam logic [6:0] PAT_1     = 7'h79;
  localparam logic [6:0] PAT_2     = 7'h24;
  localparam logic [6:0] PAT_3     = 7'h30;
  localparam logic [6:0] PAT_4     = 7'h19;
  localparam logic [6:0] PAT_5     = 7'h12;
  localparam logic [6:0] PAT_6     = 7'h02;
  localparam logic [6:0] PAT_7     = 7'h78;
  localparam logic [6:0] PAT_8     = 7'h00;
  localparam logic [6:0] PAT_9     = 7'h10;
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the segment encoder: active-low segment byte to
// hex value plus blank / decimal-point / unknown-pattern flags.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [7:0]       seg,
  output logic [DIG_W-1:0] value,
  output logic             blank,
  output logic             dp,
  output logic             err
);

  always_comb begin
    value = '0;
    blank = 1'b0;
    err   = 1'b0;
    dp    = ~seg[7];
    case (seg[6:0])
      PAT_0:     value = 4'd0;
      PAT_1:     value = 4'd1;
      PAT_2:     value = 4'd2;
      PAT_3:     value = 4'd3;
      PAT_4:     value = 4'd4;
      PAT_5:     value = 4'd5;
      PAT_6:     value = 4'd6;
      PAT_7:     value = 4'd7;
      PAT_8:     value = 4'd8;
      PAT_9:     value = 4'd9;
      PAT_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment bus monitor: captures each digit once its
// {seg, dig_n} sample has been stable for STABLE_CYC cycles.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               seg,
  input  logic [NUM_DIG-1:0]       dig_n,
  output logic [DIG_W*NUM_DIG-1:0] digits,
  output logic [NUM_DIG-1:0]       blank,
  output logic [NUM_DIG-1:0]       dp,
  output logic [NUM_DIG-1:0]       err,
  output logic                     frame_valid,
  output logic                     bus_err
);

  localparam int CNT_W  = $clog2(STABLE_CYC + 1);
  localparam int SAMP_W = 8 + NUM_DIG;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMP_W-1:0]   held_q, held_d;
  logic [NUM_DIG-1:0]  seen_q, seen_d;
  logic [SAMP_W-1:0]   sample;
  logic                one_low, invalid, reload, capture, frame_d;
  int unsigned         lows;
  logic [NUM_DIG-1:0]  cap_sel;
  logic [DIG_W-1:0]    dec_value;
  logic                dec_blank, dec_dp, dec_err;

  assign sample = {seg, dig_n};

  always_comb begin
    lows = 0;
    for (int unsigned i = 0; i < NUM_DIG; i++) begin
      if (!dig_n[i]) lows++;
    end
  end

  assign one_low = (lows == 1);
  assign invalid = (lows > 1);

  // Every capture path leaves the captured sample in held_d, so one decoder
  // on the next held value serves both the settle and single-cycle cases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    reload  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (one_low) reload = 1'b1;
      SETTLE: begin
        if (sample == held_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end else if (one_low) begin
          reload = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (sample != held_q) begin
          if (one_low) begin
            reload = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (reload) begin
      held_d = sample;
      cnt_d  = CNT_W'(1);
      if (STABLE_CYC == 1) begin
        capture = 1'b1;
        state_d = HOLD;
      end else begin
        state_d = SETTLE;
      end
    end
  end

  assign cap_sel = ~held_d[NUM_DIG-1:0];

  seg_pattern_decode u_decode (
    .seg   (held_d[NUM_DIG +: 8]),
    .value (dec_value),
    .blank (dec_blank),
    .dp    (dec_dp),
    .err   (dec_err)
  );

  always_comb begin
    seen_d  = seen_q;
    frame_d = 1'b0;
    if (capture) begin
      seen_d = seen_q | cap_sel;
      if (&seen_d) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      held_q      <= '1;
      seen_q      <= '0;
      digits      <= '0;
      blank       <= '1;
      dp          <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      seen_q      <= seen_d;
      frame_valid <= frame_d;
      bus_err     <= invalid;
      if (capture) begin
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
          if (cap_sel[i]) begin
            digits[i*DIG_W +: DIG_W] <= dec_value;
            blank[i]                 <= dec_blank;
            dp[i]                    <= dec_dp;
            err[i]                   <= dec_err;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboard bench for seg_scan_reader: a run-length reference model predicts
// every post-edge output; a separate monitor pops and compares each cycle.
module tb_seg_scan_reader;

  localparam int NUM_DIG    = 4;
  localparam int STABLE_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  seg = 8'hFF;
  logic [3:0]  dig_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank, dp, err;
  logic        frame_valid, bus_err;

  seg_scan_reader #(.NUM_DIG(NUM_DIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_n       (dig_n),
    .digits      (digits),
    .blank       (blank),
    .dp          (dp),
    .err         (err),
    .frame_valid (frame_valid),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank, dp, err;
    logic        fv, be;
  } exp_t;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] val;
  } dchk_t;

  exp_t  q[$];
  dchk_t dq[$];
  int    errors = 0;
  int    checks = 0;
  bit    started = 0;
  bit    done = 0;

  // Reference model: a digit is captured when the same valid sample has been
  // seen on exactly STABLE_CYC consecutive edges.
  logic [6:0]  pats[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [3:0]  m_dig[4];
  logic [3:0]  m_blank, m_dp, m_err, m_seen;
  logic [11:0] m_prev;
  int          m_run;
  logic        m_fv, m_be;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_blank = 4'hF; m_dp = 4'h0; m_err = 4'h0; m_seen = 4'h0;
    m_prev = '1; m_run = 0; m_fv = 0; m_be = 0;
  endfunction

  function automatic void model_step(input logic [7:0] s, input logic [3:0] d);
    int lows;
    int idx;
    logic [3:0] v;
    logic found;
    lows = $countones(~d);
    m_fv = 0;
    m_be = (lows > 1);
    if (lows == 1) begin
      if (m_run > 0 && {s, d} == m_prev) m_run++;
      else begin
        m_run  = 1;
        m_prev = {s, d};
      end
      if (m_run == STABLE_CYC) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (!d[i]) idx = i;
        v = 4'd0; found = 0;
        for (int k = 0; k < 10; k++) if (pats[k] == s[6:0]) begin v = 4'(k); found = 1; end
        m_dig[idx]   = v;
        m_blank[idx] = (s[6:0] == 7'h7F);
        m_err[idx]   = !found && (s[6:0] != 7'h7F);
        m_dp[idx]    = ~s[7];
        m_seen[idx]  = 1'b1;
        if (m_seen == 4'hF) begin
          m_fv   = 1;
          m_seen = 4'h0;
        end
      end
    end else begin
      m_run = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    e.blank = m_blank; e.dp = m_dp; e.err = m_err; e.fv = m_fv; e.be = m_be;
    return e;
  endfunction

  task automatic step(input logic [7:0] s, input logic [3:0] d, input logic r = 1'b1);
    @(negedge clk);
    seg = s; dig_n = d; rst_n = r;
    if (!r) model_reset();
    @(posedge clk);
    if (r) model_step(s, d);
    q.push_back(model_out());
    started = 1;
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(s, d);
  endtask

  task automatic post(input string n, input int f, input logic [31:0] v);
    dchk_t c;
    c.name = n; c.field = f; c.val = v;
    dq.push_back(c);
  endtask

  // Monitor: owns every comparison and both counters.
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] field_val(input int f);
    case (f)
      0: return 32'(digits);
      1: return 32'(blank);
      2: return 32'(dp);
      3: return 32'(err);
      4: return 32'(frame_valid);
      default: return 32'(bus_err);
    endcase
  endfunction

  initial begin
    exp_t  e;
    dchk_t c;
    logic  clk_edge;
    forever begin
      @(posedge clk or negedge rst_n);
      clk_edge = clk;
      #1;
      if (!clk_edge) begin
        chk("async_rst_digits", 32'(digits), 32'h0);
        chk("async_rst_blank", 32'(blank), 32'hF);
        chk("async_rst_flags", {28'd0, dp | err}, 32'h0);
        chk("async_rst_pulses", {30'd0, frame_valid, bus_err}, 32'h0);
      end else if (q.size() == 0) begin
        if (started && !done) chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("digits", 32'(digits), 32'(e.digits));
        chk("blank", 32'(blank), 32'(e.blank));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("err", 32'(err), 32'(e.err));
        chk("frame_valid", 32'(frame_valid), 32'(e.fv));
        chk("bus_err", 32'(bus_err), 32'(e.be));
        while (dq.size() > 0) begin
          c = dq.pop_front();
          chk(c.name, field_val(c.field), c.val);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    logic [3:0] d;
    int r, n;
    model_reset();
    step(8'hFF, 4'hF, 1'b0);
    step(8'hFF, 4'hF, 1'b0);

    hold(8'h99, 4'b1110, 7);
    post("pre_capture_d0", 0, 32'h0000);
    step(8'h99, 4'b1110);
    post("first_digit4", 0, 32'h0004);
    post("first_blank", 1, 32'hE);
    post("first_err", 3, 32'h0);
    post("first_dp", 2, 32'h0);

    step(8'hFF, 4'hF, 1'b0);
    hold(8'hC0, 4'b0111, 8); step(8'hFF, 4'hF);
    hold(8'hF9, 4'b1011, 8); step(8'hFF, 4'hF);
    hold(8'hA4, 4'b1101, 8); step(8'hFF, 4'hF);
    hold(8'h10, 4'b1110, 7);
    post("no_frame_yet", 4, 32'h0);
    step(8'h10, 4'b1110);
    post("scan_digits", 0, 32'h0129);
    post("scan_dp", 2, 32'h1);
    post("scan_frame", 4, 32'h1);
    step(8'hFF, 4'hF);
    post("frame_one_cycle", 4, 32'h0);

    hold(8'h82, 4'b1101, 5);
    hold(8'hF8, 4'b1101, 8);
    post("glitch_digit7", 0, 32'h0179);

    hold(8'h55, 4'b1011, 8);
    post("bad_pattern_err", 3, 32'h4);
    post("bad_pattern_val", 0, 32'h0079);
    hold(8'hFF, 4'b1011, 8);
    post("blank_clears_err", 3, 32'h0);
    post("blank_set", 1, 32'h4);

    hold(8'h99, 4'b1100, 3);
    post("bus_err_pulse", 5, 32'h1);
    hold(8'hC0, 4'b1110, 7);
    post("after_bus_err_wait", 0, 32'h0079);
    step(8'hC0, 4'b1110);
    post("after_bus_err_cap", 0, 32'h0070);

    step(8'hFF, 4'hF);
    hold(8'hF9, 4'b1110, 6);
    step(8'hF9, 4'b1110, 1'b0);
    hold(8'hF9, 4'b1110, 7);
    post("post_reset_wait", 0, 32'h0000);
    step(8'hF9, 4'b1110);
    post("post_reset_cap", 0, 32'h0001);

    for (int it = 0; it < 250; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7) s = {1'($urandom), pats[$urandom_range(0, 9)]};
      else if (r < 8) s = {1'($urandom), 7'h7F};
      else s = 8'($urandom);
      r = $urandom_range(0, 19);
      if (r < 15) d = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 18) d = 4'hF;
      else d = 4'($urandom);
      n = $urandom_range(1, 12);
      hold(s, d, n);
    end

    step(8'hFF, 4'hF);
    step(8'hFF, 4'hF);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    done = 1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_reader.md
Name: seg_scan_reader

Overview:
- Reads a multiplexed, active-low 7-segment display bus: segment lines plus active-low digit enables.
- Converts the observed segment patterns back into per-digit hex values, blank/decimal-point/error flags, and a frame-complete pulse.
- Used as a display-bus monitor for self-check and loopback of the existing segment encoding (0-9, blank = all segments off).
- Reject-on-glitch filtering means only patterns held stable for a programmable number of cycles are captured.

Parameters:
- NUM_DIG, 4: number of scanned digits; one-hot width of dig_n. Must be at least 1.
- STABLE_CYC, 8: consecutive identical samples required before a capture. Must be at least 1.
- CNT_W, $clog2(STABLE_CYC+1): stability counter width. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg  in  8  segment bus, active low. Bit 7 = dp; bits 6:0 = g..a.
- dig_n  in  NUM_DIG  digit enables, active low, expected one-hot-low.
- digits  out  4*NUM_DIG  decoded value per digit; digit i occupies bits [4i+3:4i].
- blank  out  NUM_DIG  digit i last captured as all segments off.
- dp  out  NUM_DIG  digit i decimal point lit at last capture.
- err  out  NUM_DIG  digit i last captured pattern not in the decode table.
- frame_valid  out  1  one-cycle pulse: every digit captured since the previous pulse.
- bus_err  out  1  one-cycle pulse: a sample had more than one dig_n bit low.

Behaviour:
- Reset values (async, on rst_n low):
  - digits = 0, blank = all 1, dp = 0, err = 0, frame_valid = 0, bus_err = 0.
  - FSM = IDLE, counter = 0, seen mask = 0, held sample = all 1.
- Sample validity:
  - dig_n all 1 = inter-digit gap. Legal, not captured.
  - Exactly one dig_n bit 0 = valid sample.
  - Anything else = invalid; pulse bus_err for one cycle, registered on the sampling edge.
- Decode of seg[6:0] (seg[7] is decoded separately, dp = ~seg[7]):
  - 40 = 0, 79 = 1, 24 = 2, 30 = 3, 19 = 4, 12 = 5, 02 = 6, 78 = 7, 00 = 8, 10 = 9.
  - 7F = blank: digit value 0, blank = 1.
  - Any other pattern: err = 1, digit value 0, blank = 0.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: on a valid sample, store {seg, dig_n}, counter = 1, go to SETTLE. If STABLE_CYC = 1, capture on this same edge and go to HOLD.
  - SETTLE: sample equals the held value → counter + 1; when the counter reaches STABLE_CYC, capture on that edge and go to HOLD.
  - SETTLE: sample differs → if valid, reload held value, counter = 1, stay in SETTLE; if gap or invalid, go to IDLE.
  - HOLD: same sample → stay in HOLD, no recapture.
  - HOLD: different valid sample → reload, go to SETTLE; gap or invalid → IDLE.
- Capture writes only the selected digit's digits/blank/dp/err slice and sets its seen bit. Other digits keep their values.
- Latency: if input is constant from sampling edge t, the outputs show the new values after edge t+STABLE_CYC-1.
- Frame completion:
  - On the capture edge where the seen mask becomes all 1, frame_valid = 1 for exactly one cycle and the seen mask clears to 0 on that same edge.
  - Recapturing an already-seen digit only overwrites its value; it does not change the mask.
- Simultaneous events:
  - If the input changes on the edge where the count would reach STABLE_CYC, the new value wins: no capture, counter restarts.
  - NUM_DIG = 1: frame_valid pulses on every capture.
- Reset mid-settle: partially counted data is discarded and nothing is captured.

Decomposition:
- Shared package seg_pkg holds:
  - the 7-bit pattern constants for 0-9 and blank;
  - the FSM state enum {IDLE, SETTLE, HOLD};
  - the DIG_W = 4 constant.
- One natural sub-module: seg_pattern_decode. Purely combinational; seg[7:0] in, {value[3:0], blank, dp, err} out. Instantiated once, on the held sample.

Test Plan:
- Reset, then hold seg=0x99, dig_n=4'b1110 for 8 cycles: after edge 8, digits[3:0]=4, blank[0]=0, err[0]=0, dp[0]=0.
- Scan digits 3..0 with 0xC0, 0xF9, 0xA4, 0x10 (the last with dp lit), 8 cycles each, 1-cycle gaps between digits:
  - digits = 16'h0129 (digit 3 = 0, digit 0 = 9).
  - dp = 4'b0001.
  - frame_valid is a single 1-cycle pulse on the last capture edge.
- Glitch: seg=0x82 for 5 cycles, then 0xF8 for 8 cycles on digit 1: only 7 is captured; 6 never appears on digits[7:4].
- Invalid pattern seg=0x55 for 8 cycles on digit 2: err[2]=1, digits[11:8]=0. Then seg=0xFF for 8 cycles: err[2]=0, blank[2]=1.
- dig_n=4'b1100 for 3 cycles: bus_err pulses on each sampling edge, FSM returns to IDLE, no output changes. A following valid digit still needs a full 8 cycles.
- Assert rst_n low for 1 cycle while SETTLE counter = 6: all outputs return to reset values immediately; the next capture needs a full 8 stable cycles.
